// File: rtl/ireorder_ma_pipe_if.sv
// ---------------------------------------------------------------------------
// ireorder_ma_pipe_if
// Bundles the request and response signals of the inverse re-order address
// delay pipeline.
//   en_i        advance enable (0 = stall)
//   flush_i     synchronous flush of all stages
//   rev_i       digit-reverse the addresses captured this cycle
//   ma_i        CH_NUM packed address lanes, lane k at [k*MA_WIDTH +: MA_WIDTH]
//   ma_vld_i    ma_i valid
//   irema_o     delayed addresses, same packing as ma_i
//   irema_vld_o irema_o valid
//   occ_o       number of valid entries held in the pipeline
// Modports: master drives the inputs and observes the outputs; slave is the
// pipeline itself.
// ---------------------------------------------------------------------------
interface ireorder_ma_pipe_if #(
  parameter int MA_WIDTH = 9,
  parameter int CH_NUM   = 4,
  parameter int DEPTH    = 2,
  parameter int OCC_W    = $clog2(DEPTH + 1)
);
  logic                         en_i;
  logic                         flush_i;
  logic                         rev_i;
  logic [CH_NUM*MA_WIDTH-1:0]   ma_i;
  logic                         ma_vld_i;
  logic [CH_NUM*MA_WIDTH-1:0]   irema_o;
  logic                         irema_vld_o;
  logic [OCC_W-1:0]             occ_o;

  modport master (
    output en_i, flush_i, rev_i, ma_i, ma_vld_i,
    input  irema_o, irema_vld_o, occ_o
  );

  modport slave (
    input  en_i, flush_i, rev_i, ma_i, ma_vld_i,
    output irema_o, irema_vld_o, occ_o
  );
endinterface

// File: rtl/ireorder_ma_pipe.sv
// ---------------------------------------------------------------------------
// ireorder_ma_pipe
// Multi-lane memory-address delay pipeline for the inverse re-order stage of
// the radix-16 FFT. Each address lane is delayed by DEPTH enabled cycles with
// a valid flag riding alongside; addresses may be digit-reversed at capture.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-high despite its name
//   ma_if  slave modport of ireorder_ma_pipe_if (enable, flush, reverse,
//          input addresses/valid, delayed addresses/valid, occupancy)
// Per edge priority: flush > enable > hold. Outputs come straight from the
// last stage register; occupancy is registered.
// ---------------------------------------------------------------------------
module ireorder_ma_pipe #(
  parameter int                  MA_WIDTH = 9,
  parameter int                  CH_NUM   = 4,
  parameter int                  DEPTH    = 2,
  parameter int                  DIGIT_W  = 4,
  parameter logic [MA_WIDTH-1:0] MA_ZERO  = '0,
  parameter int                  OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ireorder_ma_pipe_if.slave    ma_if
);
  localparam int                BUS_W    = CH_NUM * MA_WIDTH;
  localparam int                ND       = MA_WIDTH / DIGIT_W;
  localparam logic [BUS_W-1:0]  BUS_ZERO = {CH_NUM{MA_ZERO}};

  logic [BUS_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [BUS_W-1:0] cap_d;

  // Reverse the order of the ND low digits; bits above ND*DIGIT_W stay put.
  // With ND <= 1 this degenerates to the identity.
  function automatic logic [MA_WIDTH-1:0] digit_rev(input logic [MA_WIDTH-1:0] a);
    logic [MA_WIDTH-1:0] r;
    r = a;
    for (int i = 0; i < ND; i++) begin
      r[(ND-1-i)*DIGIT_W +: DIGIT_W] = a[i*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  always_comb begin
    cap_d = ma_if.ma_i;
    if (ma_if.rev_i) begin
      for (int k = 0; k < CH_NUM; k++) begin
        cap_d[k*MA_WIDTH +: MA_WIDTH] = digit_rev(ma_if.ma_i[k*MA_WIDTH +: MA_WIDTH]);
      end
    end
  end

  // One entry may enter and one may leave on the same edge; the count is
  // bounded by DEPTH because an entry only leaves once DEPTH have been shifted.
  always_comb begin
    occ_d = occ_q + OCC_W'(ma_if.ma_vld_i) - OCC_W'(vld_q[DEPTH-1]);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        data_q[j] <= BUS_ZERO;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (ma_if.flush_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        data_q[j] <= BUS_ZERO;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (ma_if.en_i) begin
      // Capture happens even when ma_vld_i is low; the entry is just invalid.
      data_q[0] <= cap_d;
      vld_q[0]  <= ma_if.ma_vld_i;
      for (int j = 1; j < DEPTH; j++) begin
        data_q[j] <= data_q[j-1];
        vld_q[j]  <= vld_q[j-1];
      end
      occ_q <= occ_d;
    end
  end

  assign ma_if.irema_o     = data_q[DEPTH-1];
  assign ma_if.irema_vld_o = vld_q[DEPTH-1];
  assign ma_if.occ_o       = occ_q;
endmodule

// File: tb/tb_ireorder_ma_pipe.sv
module tb_ireorder_ma_pipe;
  localparam int MAW   = 9;
  localparam int CH    = 2;
  localparam int DEP   = 2;
  localparam int DW    = 4;
  localparam int OCCW  = $clog2(DEP + 1);
  localparam int BW    = MAW * CH;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ireorder_ma_pipe_if #(.MA_WIDTH(MAW), .CH_NUM(CH), .DEPTH(DEP)) u_if ();

  ireorder_ma_pipe #(
    .MA_WIDTH(MAW), .CH_NUM(CH), .DEPTH(DEP), .DIGIT_W(DW), .MA_ZERO('0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ma_if (u_if)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pk(input logic [MAW-1:0] l1, input logic [MAW-1:0] l0);
    return {l1, l0};
  endfunction

  // Reference digit reversal by integer arithmetic on digit values.
  function automatic logic [MAW-1:0] mrev(input int a);
    int nd;
    int m;
    int r;
    nd = MAW / DW;
    m  = 1 << DW;
    if (nd <= 1) return MAW'(a);
    r = (a >> (nd * DW)) << (nd * DW);
    for (int i = 0; i < nd; i++) begin
      r += ((a >> (i * DW)) % m) << ((nd - 1 - i) * DW);
    end
    return MAW'(r);
  endfunction

  // Model: the last DEPTH captures since reset/flush. Output is the oldest
  // once DEPTH captures exist, otherwise the cleared value.
  typedef struct {
    logic [BW-1:0] d;
    bit            v;
  } ent_t;
  ent_t hist[$];

  always @(posedge clk or posedge rst_n) begin
    ent_t e;
    if (rst_n || u_if.flush_i) begin
      hist.delete();
    end else if (u_if.en_i) begin
      e.d = u_if.ma_i;
      if (u_if.rev_i) begin
        for (int k = 0; k < CH; k++) begin
          e.d[k*MAW +: MAW] = mrev(int'(u_if.ma_i[k*MAW +: MAW]));
        end
      end
      e.v = u_if.ma_vld_i;
      hist.push_back(e);
      if (hist.size() > DEP) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [BW-1:0] ed;
    logic          ev;
    int            eo;
    if (chk_on) begin
      ed = '0;
      ev = 1'b0;
      eo = 0;
      if (hist.size() == DEP) begin
        ed = hist[0].d;
        ev = hist[0].v;
      end
      foreach (hist[i]) if (hist[i].v) eo++;
      chk("model_irema", 32'(u_if.irema_o), 32'(ed));
      chk("model_vld", 32'(u_if.irema_vld_o), 32'(ev));
      chk("model_occ", 32'(u_if.occ_o), 32'(eo));
      chk("occ_bound", 32'(u_if.occ_o <= OCCW'(DEP)), 32'd1);
    end
  end

  task automatic step(input logic en, input logic fl, input logic rv, input logic vl,
                      input logic [MAW-1:0] l1, input logic [MAW-1:0] l0);
    u_if.en_i     = en;
    u_if.flush_i  = fl;
    u_if.rev_i    = rv;
    u_if.ma_vld_i = vl;
    u_if.ma_i     = pk(l1, l0);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [BW-1:0] d, input logic v, input int o);
    chk({nm, "_irema"}, 32'(u_if.irema_o), 32'(d));
    chk({nm, "_vld"}, 32'(u_if.irema_vld_o), 32'(v));
    chk({nm, "_occ"}, 32'(u_if.occ_o), 32'(o));
  endtask

  initial begin
    u_if.en_i = 1'b0; u_if.flush_i = 1'b0; u_if.rev_i = 1'b0;
    u_if.ma_vld_i = 1'b0; u_if.ma_i = '0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", '0, 1'b0, 0);
    rst_n  = 1'b0;
    chk_on = 1'b1;

    // Latency and pass-through
    step(1, 0, 0, 1, 9'h1A5, 9'h003); lit("lat_e1", '0, 1'b0, 1);
    step(1, 0, 0, 1, 9'h0F0, 9'h1A5); lit("lat_e2", pk(9'h1A5, 9'h003), 1'b1, 2);
    // Digit reverse, then rev toggled back
    step(1, 0, 1, 1, 9'h1A5, 9'h0F0); lit("rev_e3", pk(9'h0F0, 9'h1A5), 1'b1, 2);
    step(1, 0, 0, 1, 9'h1A5, 9'h1A5); lit("rev_e4", pk(9'h15A, 9'h00F), 1'b1, 2);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("rev_e5", pk(9'h1A5, 9'h1A5), 1'b1, 1);
    // Stall
    step(1, 0, 0, 1, 9'h011, 9'h022); lit("stl_a", '0, 1'b0, 1);
    step(1, 0, 0, 1, 9'h033, 9'h044); lit("stl_b", pk(9'h011, 9'h022), 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 9'h1FF, 9'h1FF); lit("stl_hold", pk(9'h011, 9'h022), 1'b1, 2);
    end
    step(1, 0, 0, 1, 9'h055, 9'h066); lit("stl_c", pk(9'h033, 9'h044), 1'b1, 2);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("stl_out_c", pk(9'h055, 9'h066), 1'b1, 1);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("stl_drain", '0, 1'b0, 0);
    // Flush priority
    step(1, 0, 0, 1, 9'h100, 9'h101);
    step(1, 0, 0, 1, 9'h102, 9'h103); lit("fl_full", pk(9'h100, 9'h101), 1'b1, 2);
    step(1, 1, 0, 1, 9'h0FF, 9'h0FF); lit("fl_edge", '0, 1'b0, 0);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("fl_after1", '0, 1'b0, 0);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("fl_after2", '0, 1'b0, 0);
    // Bubbles 1,0,1,0
    step(1, 0, 0, 1, 9'h001, 9'h011); lit("bub1", '0, 1'b0, 1);
    step(1, 0, 0, 0, 9'h002, 9'h012); lit("bub2", pk(9'h001, 9'h011), 1'b1, 1);
    step(1, 0, 0, 1, 9'h003, 9'h013); lit("bub3", pk(9'h002, 9'h012), 1'b0, 1);
    step(1, 0, 0, 0, 9'h004, 9'h014); lit("bub4", pk(9'h003, 9'h013), 1'b1, 1);
    step(1, 0, 0, 0, 9'h005, 9'h015); lit("bub5", pk(9'h004, 9'h014), 1'b0, 0);
    // Reset mid-stream
    step(1, 0, 0, 1, 9'h1AA, 9'h055);
    step(1, 0, 0, 1, 9'h0AB, 9'h0CD); lit("rst_full", pk(9'h1AA, 9'h055), 1'b1, 2);
    #2 rst_n = 1'b1;
    #1 lit("rst_async", '0, 1'b0, 0);
    #2 rst_n = 1'b0;
    step(1, 0, 0, 1, 9'h123, 9'h045); lit("rst_rel1", '0, 1'b0, 1);
    step(1, 0, 0, 0, 9'h000, 9'h000); lit("rst_rel2", pk(9'h123, 9'h045), 1'b1, 1);
    step(1, 0, 0, 0, 9'h000, 9'h000);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
